// File: rtl/uart_tx_feeder_pkg.sv
// Shared types for the UART transmit feeder: sequencer state encoding and byte width.
package uart_tx_feeder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PULSE      = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/uart_tx_feeder_fifo.sv
// Synchronous byte FIFO with occupancy count and sticky overflow flag.
module sync_byte_fifo
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] wr_data_i,
  input  logic              pop_i,
  output logic [BYTE_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o
);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q;
  logic              push_ok, pop_ok;

  // Full is judged on the pre-pop count, so a push colliding with a pop at full is dropped.
  assign full_o     = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      count_q <= count_d;
      if (push_i && full_o) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and feeds them one at a time to the UART transmitter.
//   state         | meaning
//   ST_IDLE       | waiting for a queued byte; pops it into tx_byte when present
//   ST_PULSE      | transmit high for this single cycle
//   ST_WAIT_START | waiting for is_transmitting to rise; re-pulses on timeout
//   ST_WAIT_DONE  | frame in progress; waiting for is_transmitting to fall
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int ADDR_W        = 4,
  parameter int START_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              busy,
  output logic              transmit,
  output logic [BYTE_W-1:0] tx_byte,
  input  logic              is_transmitting
);

  localparam int RETRY_W = $clog2(START_TIMEOUT + 1);

  seq_state_e        state_q, state_d;
  logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic              pop;
  logic [BYTE_W-1:0] head;

  sync_byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (wr_en),
    .wr_data_i  (wr_data),
    .pop_i      (pop),
    .rd_data_o  (head),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count),
    .overflow_o (overflow)
  );

  assign transmit = (state_q == ST_PULSE);
  assign busy     = (state_q != ST_IDLE);
  assign tx_byte  = tx_byte_q;

  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    retry_d   = retry_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          tx_byte_d = head;
          state_d   = ST_PULSE;
        end
      end
      ST_PULSE: begin
        retry_d = '0;
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (is_transmitting) begin
          state_d = ST_WAIT_DONE;
        end else begin
          retry_d = retry_q + RETRY_W'(1);
          // Counter reaching the timeout re-pulses the held byte without popping.
          if (retry_q == RETRY_W'(START_TIMEOUT - 1)) state_d = ST_PULSE;
        end
      end
      ST_WAIT_DONE: begin
        if (!is_transmitting) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tx_byte_q <= '0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      tx_byte_q <= tx_byte_d;
      retry_q   <= retry_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed self-checking bench for uart_tx_feeder with a simple 50-cycle UART model.
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, overflow, busy, transmit;
  logic [4:0] count;
  logic [7:0] tx_byte;
  logic       is_transmitting;

  logic is_tx_manual;
  logic uart_auto;
  int   model_cnt = 0;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign is_transmitting = uart_auto ? (model_cnt != 0) : is_tx_manual;

  uart_tx_feeder #(.DEPTH(16), .ADDR_W(4), .START_TIMEOUT(15)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .full            (full),
    .empty           (empty),
    .count           (count),
    .overflow        (overflow),
    .busy            (busy),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .is_transmitting (is_transmitting)
  );

  // UART model: a frame lasts 50 cycles starting right after the transmit pulse.
  always @(posedge clk) begin
    if (uart_auto && transmit && model_cnt == 0) model_cnt <= 50;
    else if (model_cnt != 0)                     model_cnt <= model_cnt - 1;
  end

  // Pulse monitor, sampled on the falling edge.
  int         cyc = 0;
  int         fall_cyc = 0;
  logic       prev_tx = 1'b0;
  logic       prev_transmit = 1'b0;
  bit         dbl = 1'b0;
  logic [7:0] byte_q[$];
  int         pcyc_q[$];
  int         gap_q[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (prev_tx && !is_transmitting) fall_cyc = cyc;
    if (rst_n === 1'b1 && transmit === 1'b1) begin
      byte_q.push_back(tx_byte);
      pcyc_q.push_back(cyc);
      gap_q.push_back(cyc - fall_cyc);
      if (prev_transmit) dbl = 1'b1;
    end
    prev_tx       = is_transmitting;
    prev_transmit = transmit;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k = 0;
    while (!(empty && !busy) && k < max) begin
      tick();
      k++;
    end
    check(tag, 32'(k < max), 32'd1);
  endtask

  int mark;

  initial begin
    rst_n        = 1'b0;
    wr_en        = 1'b0;
    wr_data      = 8'h00;
    is_tx_manual = 1'b0;
    uart_auto    = 1'b0;
    #3;
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_full",     32'(full),     32'd0);
    check("rst_count",    32'(count),    32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_transmit", 32'(transmit), 32'd0);
    check("rst_tx_byte",  32'(tx_byte),  32'h00);
    tick(2);
    rst_n = 1'b1;
    tick();

    // Single byte latency and handshake.
    mark = byte_q.size();
    push_byte(8'h41);
    check("single_count1",   32'(count),    32'd1);
    check("single_tx_early", 32'(transmit), 32'd0);
    tick();
    check("single_transmit", 32'(transmit), 32'd1);
    check("single_tx_byte",  32'(tx_byte),  32'h41);
    check("single_busy",     32'(busy),     32'd1);
    check("single_empty",    32'(empty),    32'd1);
    tick();
    check("single_pulse_end", 32'(transmit), 32'd0);
    is_tx_manual = 1'b1;
    tick(100);
    check("single_busy_hold", 32'(busy), 32'd1);
    check("single_npulses",   32'(byte_q.size() - mark), 32'd1);
    is_tx_manual = 1'b0;
    tick();
    check("single_busy_fall", 32'(busy),    32'd0);
    check("single_empty_end", 32'(empty),   32'd1);
    check("single_byte_hold", 32'(tx_byte), 32'h41);

    // Burst ordering against the UART model.
    uart_auto = 1'b1;
    mark = byte_q.size();
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    wait_idle("burst_drain_timeout", 1000);
    check("burst_npulses", 32'(byte_q.size() - mark), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (mark + i < byte_q.size()) check("burst_byte", 32'(byte_q[mark + i]), 32'(i + 1));
      if (i > 0 && mark + i < gap_q.size()) check("burst_gap", 32'(gap_q[mark + i]), 32'd2);
    end

    // Fill to full with is_transmitting held high, then overflow.
    uart_auto    = 1'b0;
    is_tx_manual = 1'b1;
    do_reset();
    mark = byte_q.size();
    for (int i = 0; i < 17; i++) push_byte(8'h10 + 8'(i));
    check("ovf_full",      32'(full),     32'd1);
    check("ovf_count16",   32'(count),    32'd16);
    check("ovf_not_yet",   32'(overflow), 32'd0);
    push_byte(8'h21);
    check("ovf_set",       32'(overflow), 32'd1);
    check("ovf_count_hold", 32'(count),   32'd16);
    uart_auto = 1'b1;
    wait_idle("ovf_drain_timeout", 3000);
    check("ovf_npulses", 32'(byte_q.size() - mark), 32'd17);
    for (int i = 0; i < 17; i++)
      if (mark + i < byte_q.size()) check("ovf_byte", 32'(byte_q[mark + i]), 32'h10 + 32'(i));
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Push colliding with pop while full.
    uart_auto    = 1'b0;
    is_tx_manual = 1'b1;
    do_reset();
    mark = byte_q.size();
    for (int i = 0; i < 17; i++) push_byte(8'h30 + 8'(i));
    check("col_count16", 32'(count),    32'd16);
    check("col_ovf0",    32'(overflow), 32'd0);
    check("col_busy",    32'(busy),     32'd1);
    is_tx_manual = 1'b0;
    tick();
    check("col_idle",    32'(busy), 32'd0);
    check("col_full",    32'(full), 32'd1);
    push_byte(8'hAA);
    check("col_count15", 32'(count),    32'd15);
    check("col_ovf1",    32'(overflow), 32'd1);
    check("col_transmit", 32'(transmit), 32'd1);
    check("col_tx_byte", 32'(tx_byte),  32'h31);
    uart_auto = 1'b1;
    wait_idle("col_drain_timeout", 3000);
    check("col_npulses", 32'(byte_q.size() - mark), 32'd17);
    if (byte_q.size() > 0) check("col_last_byte", 32'(byte_q[byte_q.size() - 1]), 32'h40);

    // Start timeout re-pulses the same byte every 16 cycles.
    uart_auto    = 1'b0;
    is_tx_manual = 1'b0;
    do_reset();
    mark = byte_q.size();
    push_byte(8'h5A);
    push_byte(8'h5B);
    tick(50);
    check("to_npulses", 32'(byte_q.size() - mark), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (mark + k < byte_q.size()) check("to_byte", 32'(byte_q[mark + k]), 32'h5A);
      if (k > 0 && mark + k < pcyc_q.size())
        check("to_interval", 32'(pcyc_q[mark + k] - pcyc_q[mark + k - 1]), 32'd16);
    end
    is_tx_manual = 1'b1;
    tick(20);
    check("to_no_repulse", 32'(byte_q.size() - mark), 32'd4);
    check("to_busy",       32'(busy), 32'd1);
    is_tx_manual = 1'b0;
    tick(5);
    check("to_npulses_next", 32'(byte_q.size() - mark), 32'd5);
    if (byte_q.size() > 0) check("to_next_byte", 32'(byte_q[byte_q.size() - 1]), 32'h5B);
    check("to_count0", 32'(count), 32'd0);

    // Asynchronous reset mid-frame.
    is_tx_manual = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i));
    tick(2);
    check("ar_count3", 32'(count), 32'd3);
    check("ar_busy",   32'(busy),  32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_count",    32'(count),    32'd0);
    check("ar_empty",    32'(empty),    32'd1);
    check("ar_full",     32'(full),     32'd0);
    check("ar_overflow", 32'(overflow), 32'd0);
    check("ar_busy0",    32'(busy),     32'd0);
    check("ar_transmit", 32'(transmit), 32'd0);
    check("ar_tx_byte",  32'(tx_byte),  32'h00);
    mark  = byte_q.size();
    rst_n = 1'b1;
    tick(30);
    is_tx_manual = 1'b0;
    tick(170);
    check("ar_no_pulse",  32'(byte_q.size() - mark), 32'd0);
    check("ar_idle",      32'(busy),  32'd0);
    check("ar_empty_end", 32'(empty), 32'd1);

    check("no_double_pulse", 32'(dbl), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
